// File: rtl/uart_pkg.sv
// Definitions shared by the UART transmit and receive paths.
package uart_pkg;

    localparam int DataBits          = 8;
    localparam int DefaultOversample = 16;

    // Position within a serial frame, common to both directions.
    typedef enum logic [1:0] {
        FB_START = 2'd0,
        FB_DATA  = 2'd1,
        FB_STOP  = 2'd2
    } frame_bit_e;

endpackage

// File: rtl/uart_tx.sv
// UART transmitter: start bit, 8 data bits MSB-first, stop bit, each Oversample cycles; line falls the cycle after accept.
// Accepts a byte only in IDLE or the final stop-bit cycle; valid is ignored otherwise.
module uart_tx
    import uart_pkg::*;
#(
    parameter int Oversample = DefaultOversample
) (
    input  logic                clk,
    input  logic                nReset,
    input  logic [DataBits-1:0] data,
    input  logic                valid,
    output logic                ready,
    output logic                out,
    output logic                busy,
    output logic                done
);

    localparam int                CntW      = $clog2(Oversample);
    localparam logic [CntW-1:0]   CntReload = CntW'(Oversample - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_e;

    state_e                state_q, state_d;
    logic [CntW-1:0]       sample_cnt_q, sample_cnt_d;
    logic [2:0]            bit_cnt_q, bit_cnt_d;
    logic [DataBits-1:0]   tx_buf_q, tx_buf_d;
    logic                  out_q, out_d;
    logic                  bit_end;

    assign bit_end = (sample_cnt_q == '0);

    always_comb begin
        state_d      = state_q;
        sample_cnt_d = sample_cnt_q - CntW'(1);
        bit_cnt_d    = bit_cnt_q;
        tx_buf_d     = tx_buf_q;

        case (state_q)
            IDLE: begin
                sample_cnt_d = CntReload;
                if (valid) begin
                    state_d  = START;
                    tx_buf_d = data;
                end
            end
            START: begin
                if (bit_end) begin
                    state_d      = DATA;
                    bit_cnt_d    = 3'd7;
                    sample_cnt_d = CntReload;
                end
            end
            DATA: begin
                if (bit_end) begin
                    sample_cnt_d = CntReload;
                    if (bit_cnt_q == 3'd0) begin
                        state_d = STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q - 3'd1;
                        tx_buf_d  = {tx_buf_q[DataBits-2:0], 1'b0};
                    end
                end
            end
            STOP: begin
                if (bit_end) begin
                    sample_cnt_d = CntReload;
                    // Chaining straight into START keeps back-to-back frames gap-free.
                    if (valid) begin
                        state_d  = START;
                        tx_buf_d = data;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Line level is computed from the next state so out stays a pure flop output.
        case (state_d)
            START:   out_d = 1'b0;
            DATA:    out_d = tx_buf_d[DataBits-1];
            default: out_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            state_q      <= IDLE;
            sample_cnt_q <= CntReload;
            bit_cnt_q    <= 3'd7;
            tx_buf_q     <= '0;
            out_q        <= 1'b1;
        end else begin
            state_q      <= state_d;
            sample_cnt_q <= sample_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            tx_buf_q     <= tx_buf_d;
            out_q        <= out_d;
        end
    end

    assign out   = out_q;
    assign ready = (state_q == IDLE) || ((state_q == STOP) && bit_end);
    assign done  = (state_q == STOP) && bit_end;
    assign busy  = (state_q != IDLE);

endmodule
